// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract issue stage.
package addsub_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef struct packed {
        logic [DATA_W-1:0] ans;
        logic              cout;
        logic              v;
        logic              n;
        logic              z;
    } resp_t;

    // Response written for CLR regardless of adder output.
    localparam resp_t RESP_CLR = '{ans: '0, cout: 1'b0, v: 1'b0, n: 1'b0, z: 1'b1};

    function automatic resp_t make_resp(input logic [DATA_W-1:0] ans, input logic cout,
                                        input logic v);
        resp_t r;
        r.ans  = ans;
        r.cout = cout;
        r.v    = v;
        r.n    = ans[DATA_W-1];
        r.z    = (ans == '0);
        return r;
    endfunction

endpackage

// File: rtl/addsub32.sv
// 32-bit ripple-carry adder/subtractor; v is the carry into the MSB xor carry out.
module addsub32
    import addsub_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] ans,
    output logic              cout,
    output logic              v
);

    logic [DATA_W:0]   c;
    logic [DATA_W-1:0] bx;

    // Ripple chain; subtraction is a + ~b + 1 with the +1 as carry-in.
    always_comb begin
        bx   = b ^ {DATA_W{sub}};
        c    = '0;
        c[0] = sub;
        ans  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ans[i]  = a[i] ^ bx[i] ^ c[i];
            c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout = c[DATA_W];
    assign v    = c[DATA_W-1] ^ c[DATA_W];

endmodule

// File: rtl/resp_fifo.sv
// DEPTH-entry shift-register FIFO of responses; the head always sits in mem_q[0].
module resp_fifo
    import addsub_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  resp_t wdata,
    input  logic  pop,
    output resp_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    resp_t          mem_q [DEPTH];
    resp_t          mem_d [DEPTH];
    logic  [CW-1:0] count_q, count_d, wr_idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[0];

    // Shift on pop, then write the new entry just behind the last valid one.
    always_comb begin
        mem_d   = mem_q;
        wr_idx  = count_q - CW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
        end
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CW'(i) == wr_idx) begin
                    mem_d[i] = wdata;
                end
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/addsub_issue_stage.sv
// Request/response stage around addsub32 with accumulator and in-order response FIFO.
// Optional feature macro: ADDSUB_STICKY_OVF_EN adds the ovf_sticky output.
module addsub_issue_stage
    import addsub_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ans,
    output logic              out_cout,
    output logic              out_v,
    output logic              out_n,
    output logic              out_z,
`ifdef ADDSUB_STICKY_OVF_EN
    output logic              ovf_sticky,
`endif
    output logic [DATA_W-1:0] acc
);

    logic              s1_v_q;
    op_e               s1_op_q;
    logic [DATA_W-1:0] s1_a_q, s1_b_q, acc_q;
    logic [DATA_W-1:0] add_a, add_ans;
    logic              add_sub, add_cout, add_v;
    logic              push, pop, accept, fifo_full, fifo_empty;
    resp_t             res, head;

    // Adder operand selection and response formatting for the op held in S1.
    always_comb begin
        add_a   = (s1_op_q == OP_ACC) ? acc_q : s1_a_q;
        add_sub = (s1_op_q == OP_SUB);
        res     = (s1_op_q == OP_CLR) ? RESP_CLR : make_resp(add_ans, add_cout, add_v);
    end

    addsub32 u_addsub32 (
        .a    (add_a),
        .b    (s1_b_q),
        .sub  (add_sub),
        .ans  (add_ans),
        .cout (add_cout),
        .v    (add_v)
    );

    // Handshake: a pop frees a slot for a push in the same cycle, which frees S1.
    always_comb begin
        pop      = !fifo_empty && out_ready;
        push     = s1_v_q && (!fifo_full || pop);
        in_ready = rst_n && (!s1_v_q || push);
        accept   = in_valid && in_ready;
    end

    // S1 request register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_op_q <= OP_ADD;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
        end else if (accept) begin
            s1_v_q  <= 1'b1;
            s1_op_q <= op_e'(in_op);
            s1_a_q  <= in_a;
            s1_b_q  <= in_b;
        end else if (push) begin
            s1_v_q  <= 1'b0;
        end
    end

    // Accumulator updates when its ACC/CLR leaves S1, so a following ACC sees it directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (push && s1_op_q == OP_ACC) begin
            acc_q <= add_ans;
        end else if (push && s1_op_q == OP_CLR) begin
            acc_q <= '0;
        end
    end

    resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (res),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_ans   = head.ans;
    assign out_cout  = head.cout;
    assign out_v     = head.v;
    assign out_n     = head.n;
    assign out_z     = head.z;
    assign acc       = acc_q;

`ifdef ADDSUB_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: set by any pushed V, cleared by a pushed CLR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (push) begin
            if (s1_op_q == OP_CLR) begin
                sticky_q <= 1'b0;
            end else if (res.v) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign ovf_sticky = sticky_q;
`else
    // No sticky overflow flag in this build.
`endif

endmodule
